// File: rtl/operand_entry.sv
// Front-panel operand entry: synchronises and debounces four active-low buttons and
// edits the two calculator operands N1/N2 with inc/dec/clear and hold-to-repeat.
module operand_entry #(
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_CYCLES = 8,
    parameter int MAX_VAL       = 99
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       En,
    input  logic       BSel,
    input  logic       BInc,
    input  logic       BDec,
    input  logic       BClr,
    output logic [6:0] N1,
    output logic [6:0] N2,
    output logic       Sel,
    output logic       Valid
);

    localparam int         FW   = $clog2(DEB_CYCLES + 1);
    localparam int         RW   = $clog2(2 * REPEAT_CYCLES + 1);
    localparam logic [6:0] MAXV = 7'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, EDIT_N1, EDIT_N2} state_t;

    state_t        state, state_nxt;
    logic [3:0]    raw, sync1, sync2, deb, deb_q;
    logic [FW-1:0] fcnt [4];
    logic [RW-1:0] rpt_cnt;
    logic          sel_rel, clr_rel, inc_press, dec_press;
    logic          inc_held, dec_held, rpt_run, rpt_evt, inc_evt, dec_evt;
    logic [6:0]    cur, nv, n1_nxt, n2_nxt;
    logic          valid_nxt;

    // Bit order: 0 = Sel, 1 = Inc, 2 = Dec, 3 = Clr; all levels active-low.
    assign raw = {BClr, BDec, BInc, BSel};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_q <= '1;
            for (int unsigned i = 0; i < 4; i++) fcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (fcnt[i] == FW'(DEB_CYCLES - 1)) begin
                        deb[i]  <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 1'b1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    assign sel_rel   = ~deb_q[0] &  deb[0];
    assign inc_press =  deb_q[1] & ~deb[1];
    assign dec_press =  deb_q[2] & ~deb[2];
    assign clr_rel   = ~deb_q[3] &  deb[3];

    // Repeat timer runs only while exactly one of Inc/Dec is held; reload after the
    // first repeat shortens the following periods to REPEAT_CYCLES.
    assign inc_held = ~deb[1];
    assign dec_held = ~deb[2];
    assign rpt_run  = En & (inc_held ^ dec_held);
    assign rpt_evt  = rpt_run & (rpt_cnt == RW'(2 * REPEAT_CYCLES));
    assign inc_evt  = inc_press | (rpt_evt & inc_held);
    assign dec_evt  = dec_press | (rpt_evt & dec_held);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          rpt_cnt <= '0;
        else if (!rpt_run) rpt_cnt <= '0;
        else if (rpt_evt)  rpt_cnt <= RW'(REPEAT_CYCLES + 1);
        else               rpt_cnt <= rpt_cnt + 1'b1;
    end

    always_comb begin
        cur = (state == EDIT_N2) ? N2 : N1;
        nv  = cur;
        if (clr_rel)                 nv = '0;
        else if (inc_evt && !dec_evt) nv = (cur == MAXV) ? '0 : cur + 7'd1;
        else if (dec_evt && !inc_evt) nv = (cur == '0) ? MAXV : cur - 7'd1;
    end

    always_comb begin
        state_nxt = state;
        n1_nxt    = N1;
        n2_nxt    = N2;
        if (!En) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = EDIT_N1;
                    n1_nxt    = '0;
                    n2_nxt    = '0;
                end
                EDIT_N1: begin
                    n1_nxt = nv;
                    if (sel_rel) state_nxt = EDIT_N2;
                end
                EDIT_N2: begin
                    n2_nxt = nv;
                    if (sel_rel) state_nxt = EDIT_N1;
                end
                default: state_nxt = IDLE;
            endcase
        end
        valid_nxt = (n1_nxt != N1) || (n2_nxt != N2);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            N1    <= '0;
            N2    <= '0;
            Valid <= 1'b0;
        end else begin
            state <= state_nxt;
            N1    <= n1_nxt;
            N2    <= n2_nxt;
            Valid <= valid_nxt;
        end
    end

    assign Sel = (state == EDIT_N2);

endmodule
